// File: rtl/qdec_pkg.sv
// Shared definitions for the quadrature decoder: phase encodings, direction
// type, the wrap-limit helper and the forward-successor lookup.
package qdec_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    typedef enum logic {
        DIR_REV = 1'b0,
        DIR_FWD = 1'b1
    } dir_e;

    // Wrap limit is PPR clamped to the largest positive value a w-bit signed count holds.
    function automatic logic [31:0] lim_calc(input logic [31:0] ppr, input int w);
        logic [31:0] smax;
        smax = (32'd1 << (w - 1)) - 32'd1;
        return (ppr < smax) ? ppr : smax;
    endfunction

    function automatic logic fwd_step(input logic [1:0] prev, input logic [1:0] cur);
        logic res;
        case (prev)
            PH_00:   res = (cur == PH_10);
            PH_10:   res = (cur == PH_11);
            PH_11:   res = (cur == PH_01);
            PH_01:   res = (cur == PH_00);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// One-bit channel conditioner: two-flop synchroniser followed by an agreement
// counter that only lets the output move after FILT_LEN consistent samples.
module qdec_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] LEN = 4'(FILT_LEN);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q, filt_d;
    logic [3:0] cnt_q, cnt_d;

    // Next-state: count consecutive samples that disagree with the filtered value.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = 4'd0;
        if (sync2_q != filt_q) begin
            if ((cnt_q + 4'd1) >= LEN) begin
                filt_d = sync2_q;
                cnt_d  = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cnt_d = 4'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: filters A/B/Z, decodes 4x edges and keeps a
// signed position count that wraps to zero at +/-LIM.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int W        = 10,
    parameter int FILT_LEN = 3,
    parameter int INDEX_EN = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         ENC_A,
    input  logic         ENC_B,
    input  logic         ENC_Z,
    input  logic [W-1:0] PPR,
    input  logic         CLR,
    input  logic         CLR_ERR,
    output logic [W-1:0] P,
    output logic         DIR,
    output logic         STEP,
    output logic         ERR
);

    // The filters need this many cycles after reset before their outputs reflect the inputs.
    localparam logic [4:0]   WARM = 5'(FILT_LEN + 2);
    localparam logic [W-1:0] ZERO = W'(0);
    localparam logic [W-1:0] ONE  = W'(1);

    logic a_f_s, b_f_s, z_f_s;

    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(CLK), .rst_n(RST_N), .din(ENC_A), .dout(a_f_s));
    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(CLK), .rst_n(RST_N), .din(ENC_B), .dout(b_f_s));
    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (.clk(CLK), .rst_n(RST_N), .din(ENC_Z), .dout(z_f_s));

    logic [1:0]   ph_q, ph_d;
    logic         prime_q, prime_d;
    logic [4:0]   warm_q, warm_d;
    logic         z_prev_q, z_prev_d;
    logic [W-1:0] p_q, p_d;
    dir_e         dir_q, dir_d;
    logic         step_q, step_d;
    logic         err_q, err_d;

    logic [1:0]   cur_s;
    logic [W-1:0] lim_s, p_inc_s, p_dec_s;
    logic         illegal_s, fwd_s, count_s, index_s;

    // Edge classification and wrapped increment/decrement candidates.
    always_comb begin
        cur_s     = {a_f_s, b_f_s};
        lim_s     = W'(lim_calc(32'(PPR), W));
        illegal_s = !prime_q && ((cur_s ^ ph_q) == 2'b11);
        fwd_s     = fwd_step(ph_q, cur_s);
        count_s   = !prime_q && (cur_s != ph_q) && !illegal_s;
        index_s   = (INDEX_EN != 0) && !prime_q && z_f_s && !z_prev_q;
        p_inc_s   = ($signed(p_q) >= $signed(lim_s))  ? ZERO : (p_q + ONE);
        p_dec_s   = ($signed(p_q) <= -$signed(lim_s)) ? ZERO : (p_q - ONE);
    end

    // Next-state: phase tracking, error flag, direction and count with clear/index priority.
    always_comb begin
        ph_d     = ph_q;
        prime_d  = prime_q;
        warm_d   = warm_q;
        z_prev_d = z_f_s;
        dir_d    = dir_q;
        err_d    = err_q && !CLR_ERR;
        p_d      = p_q;
        step_d   = 1'b0;

        if (prime_q) begin
            if (warm_q == WARM) begin
                ph_d    = cur_s;
                prime_d = 1'b0;
            end else begin
                warm_d = warm_q + 5'd1;
            end
        end else if (illegal_s) begin
            ph_d  = cur_s;
            err_d = 1'b1;
        end else if (count_s) begin
            ph_d  = cur_s;
            dir_d = fwd_s ? DIR_FWD : DIR_REV;
        end else begin
            ph_d = ph_q;
        end

        // A count swallowed by CLR or index still moved DIR above.
        if (CLR || index_s) begin
            p_d    = ZERO;
            step_d = 1'b0;
        end else if (count_s) begin
            p_d    = fwd_s ? p_inc_s : p_dec_s;
            step_d = 1'b1;
        end else begin
            p_d    = p_q;
            step_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph_q     <= PH_00;
            prime_q  <= 1'b1;
            warm_q   <= 5'd0;
            z_prev_q <= 1'b0;
            p_q      <= ZERO;
            dir_q    <= DIR_REV;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ph_q     <= ph_d;
            prime_q  <= prime_d;
            warm_q   <= warm_d;
            z_prev_q <= z_prev_d;
            p_q      <= p_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
        end
    end

    assign P    = p_q;
    assign DIR  = dir_q;
    assign STEP = step_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: stimulus pushes expected (P, DIR) per
// counted edge; a negedge monitor pops and compares on every STEP pulse.
module tb_quad_decoder;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enc_a = 1'b0;
    logic         enc_b = 1'b0;
    logic         enc_z = 1'b0;
    logic         clr = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] ppr = 10'd599;
    logic [W-1:0] p;
    logic         dir, step, err;

    quad_decoder #(.W(W), .FILT_LEN(3), .INDEX_EN(1)) dut (
        .CLK(clk), .RST_N(rst_n), .ENC_A(enc_a), .ENC_B(enc_b), .ENC_Z(enc_z),
        .PPR(ppr), .CLR(clr), .CLR_ERR(clr_err),
        .P(p), .DIR(dir), .STEP(step), .ERR(err)
    );

    always #5 clk = ~clk;

    logic [1:0] seq [4];
    int idx, mp, lim, lat, sc;
    int checks = 0;
    int failures = 0;
    int step_cnt = 0;
    int exp_p [$];
    bit exp_d [$];
    bit seen [4];
    int mon_pv, mon_ep;
    bit mon_ed;

    function automatic int pval();
        return int'($signed(p));
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ppr(input int v);
        ppr = W'(v);
        lim = (v > 511) ? 511 : v;
    endtask

    task automatic fwd(input int n);
        for (int i = 0; i < n; i++) begin
            idx = (idx + 1) % 4;
            {enc_a, enc_b} = seq[idx];
            mp = (mp >= lim) ? 0 : mp + 1;
            exp_p.push_back(mp);
            exp_d.push_back(1'b1);
            wait_clk(8);
        end
    endtask

    task automatic rev(input int n);
        for (int i = 0; i < n; i++) begin
            idx = (idx + 3) % 4;
            {enc_a, enc_b} = seq[idx];
            mp = (mp <= -lim) ? 0 : mp - 1;
            exp_p.push_back(mp);
            exp_d.push_back(1'b0);
            wait_clk(8);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_p.size() != 0 && n < 50) begin
            wait_clk(1);
            n++;
        end
        chk(nm, exp_p.size(), 0);
    endtask

    // Monitor: every STEP pulse must match the oldest expected count.
    always @(negedge clk) begin
        if (step) begin
            step_cnt++;
            mon_pv = int'($signed(p));
            if (mon_pv == 200)  seen[0] = 1'b1;
            if (mon_pv == 144)  seen[1] = 1'b1;
            if (mon_pv == -127) seen[2] = 1'b1;
            if (mon_pv == -188) seen[3] = 1'b1;
            checks++;
            if (exp_p.size() == 0) begin
                failures++;
                $display("FAIL unexpected_step actual_p=%0d expected=no_step", mon_pv);
            end else begin
                mon_ep = exp_p.pop_front();
                mon_ed = exp_d.pop_front();
                if (mon_pv != mon_ep || dir != mon_ed) begin
                    failures++;
                    $display("FAIL step_value actual_p=%0d dir=%0d expected_p=%0d dir=%0d",
                             mon_pv, dir, mon_ep, mon_ed);
                end
            end
        end
    end

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        idx = 0; mp = 0;
        set_ppr(599);
        wait_clk(3);
        chk("rst_p", pval(), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;
        wait_clk(10);

        // First edge latency, then the rest of 10 forward cycles
        idx = 1; {enc_a, enc_b} = seq[1]; mp = 1;
        exp_p.push_back(1); exp_d.push_back(1'b1);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            wait_clk(1);
            if (lat == 0 && p != 10'd0) lat = i;
        end
        chk("first_edge_latency", lat, 6);
        fwd(39);
        drain("t1_drain");
        chk("t1_p40", pval(), 40);
        chk("t1_dir", int'(dir), 1);
        chk("t1_steps", step_cnt, 40);

        // PPR=399 wrap both ways
        set_ppr(399);
        fwd(359);
        drain("t2_drain_a");
        chk("t2_p399", pval(), 399);
        fwd(1);
        drain("t2_drain_b");
        chk("t2_wrap_pos", pval(), 0);
        rev(399);
        drain("t2_drain_c");
        chk("t2_pm399", pval(), -399);
        rev(1);
        drain("t2_drain_d");
        chk("t2_wrap_neg", pval(), 0);
        chk("t2_seen200", int'(seen[0]), 1);
        chk("t2_seen144", int'(seen[1]), 1);
        chk("t2_seen_m127", int'(seen[2]), 1);
        chk("t2_seen_m188", int'(seen[3]), 1);

        // PPR=599 clamps to LIM=511
        set_ppr(599);
        fwd(511);
        drain("t3_drain_a");
        chk("t3_p511", pval(), 511);
        fwd(1);
        drain("t3_drain_b");
        chk("t3_wrap", pval(), 0);
        sc = step_cnt;
        enc_a = ~enc_a;
        wait_clk(2);
        enc_a = ~enc_a;
        wait_clk(12);
        chk("glitch_p", pval(), 0);
        chk("glitch_steps", step_cnt, sc);

        // Illegal transition and CLR_ERR
        idx = (idx + 2) % 4; {enc_a, enc_b} = seq[idx];
        wait_clk(10);
        chk("illegal_err", int'(err), 1);
        chk("illegal_p", pval(), 0);
        chk("illegal_steps", step_cnt, sc);
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        wait_clk(1);
        chk("clr_err", int'(err), 0);
        idx = (idx + 2) % 4; {enc_a, enc_b} = seq[idx];
        wait_clk(5);
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        chk("illegal_with_clr_err", int'(err), 1);
        chk("illegal2_steps", step_cnt, sc);

        // Index coinciding with a forward edge
        fwd(38);
        rev(1);
        drain("t5_drain_a");
        chk("t5_p37", pval(), 37);
        chk("t5_dir_rev", int'(dir), 0);
        sc = step_cnt;
        idx = (idx + 1) % 4; {enc_a, enc_b} = seq[idx];
        enc_z = 1'b1;
        wait_clk(10);
        enc_z = 1'b0;
        wait_clk(8);
        mp = 0;
        chk("index_p", pval(), 0);
        chk("index_dir", int'(dir), 1);
        chk("index_steps", step_cnt, sc);

        // CLR coinciding with a counted edge
        fwd(5);
        drain("t6_drain_a");
        chk("t6_p5", pval(), 5);
        sc = step_cnt;
        idx = (idx + 1) % 4; {enc_a, enc_b} = seq[idx];
        wait_clk(5);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        wait_clk(4);
        mp = 0;
        chk("clr_count_p", pval(), 0);
        chk("clr_count_steps", step_cnt, sc);

        // CLR coinciding with the filtered Z edge
        fwd(3);
        drain("t6_drain_b");
        chk("t6_p3", pval(), 3);
        enc_z = 1'b1;
        wait_clk(5);
        clr = 1'b1;
        wait_clk(1);
        clr = 1'b0;
        chk("clr_index_p", pval(), 0);
        wait_clk(6);
        enc_z = 1'b0;
        wait_clk(8);
        mp = 0;

        // Asynchronous reset mid-count, then PRIME load with A=B=1
        fwd(88);
        drain("t7_drain_a");
        chk("t7_p88", pval(), 88);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_p", pval(), 0);
        chk("arst_dir", int'(dir), 0);
        chk("arst_step", int'(step), 0);
        chk("arst_err", int'(err), 0);
        enc_a = 1'b1; enc_b = 1'b1; idx = 2; mp = 0;
        wait_clk(3);
        rst_n = 1'b1;
        sc = step_cnt;
        wait_clk(15);
        chk("prime_p", pval(), 0);
        chk("prime_steps", step_cnt, sc);
        chk("prime_err", int'(err), 0);
        fwd(1);
        drain("t7_drain_b");
        chk("after_prime_p", pval(), 1);
        chk("after_prime_dir", int'(dir), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature encoder front end: samples raw A/B/Z encoder channels, synchronises and glitch-filters them, and decodes 4x edges.
- Maintains a signed revolution-relative count P that wraps at ±PPR.
- Sits directly upstream of the position converter and drives its P input; the PPR bus is shared with that stage.

Parameters:
- W, 10, width of P and PPR; P is two's complement.
- FILT_LEN, 3, consecutive identical synchronised samples required before a channel's filtered value changes (1..15).
- INDEX_EN, 1, 1 = filtered Z rising edge zeroes the count; 0 = Z ignored.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- ENC_A  in  1  raw encoder channel A (asynchronous).
- ENC_B  in  1  raw encoder channel B (asynchronous).
- ENC_Z  in  1  raw index channel (asynchronous).
- PPR  in  W  wrap limit, unsigned, quasi-static.
- CLR  in  1  synchronous count clear.
- CLR_ERR  in  1  synchronous clear of ERR.
- P  out  W  signed position count.
- DIR  out  1  direction of the last counted step; 1 = forward.
- STEP  out  1  one-cycle pulse on every P change caused by a count.
- ERR  out  1  sticky illegal-transition flag.

Behaviour:
- Reset (async, RST_N=0): P=0, DIR=0, STEP=0, ERR=0; synchronisers, filters and phase register cleared; PRIME flag set.
- Synchronisation: two flops per channel.
- Filter: per-channel counter. The filtered value takes the synchronised value after FILT_LEN consecutive equal samples that differ from the current filtered value. Any disagreement restarts the counter.
- Latency: raw edge to P/STEP update = 2 + FILT_LEN + 1 cycles (6 at defaults).
- Phase register holds filtered {A,B}, compared against its previous value each cycle:
  - Forward (+1): 00→10→11→01→00.
  - Reverse (−1): the opposite order.
  - No change: no action.
  - Both bits changed: illegal. Set ERR; no count; phase register adopts the new value.
- PRIME: the first filtered phase after reset is loaded without counting or flagging, then PRIME clears.
- LIM = min(PPR, 2^(W−1)−1), computed combinationally from PPR.
- Count update:
  - +1 with P==LIM gives P=0.
  - −1 with P==−LIM gives P=0.
  - Otherwise P±1.
  - PPR==0: LIM=0, so P stays 0, but STEP and DIR still update.
  - PPR changed while P is outside ±LIM: the next step in the away-from-zero direction wraps to 0; a step toward zero counts normally.
- On every count: STEP=1 for one cycle and DIR updated. Otherwise STEP=0.
- Index (INDEX_EN=1): a filtered Z rising edge forces P=0 and STEP=0.
- Priority when events coincide: CLR > index > count. A discarded count still updates DIR.
- CLR_ERR clears ERR unless an illegal transition occurs in the same cycle; in that case ERR stays 1.
- All outputs are registered.

Decomposition:
- Package qdec_pkg:
  - Phase encoding constants PH_00, PH_10, PH_11, PH_01.
  - Direction enum DIR_FWD / DIR_REV.
  - Function lim_calc(PPR, W).
- Sub-module qdec_filter: 2-flop synchroniser plus FILT_LEN agreement counter, one bit wide. Instantiated 3x (A, B, Z).

Test Plan:
- Reset, PPR=599, 10 forward quadrature cycles (40 edges, each level held 8 clk) → P=40, DIR=1, 40 STEP pulses; first P change 6 clk after the first raw edge.
- PPR=399, drive to P=399, one more forward edge → P=0. Reverse from 0 to P=−399, one more reverse edge → P=0. Ensure P=200, 144, −127, −188 are each observed on the way.
- PPR=599 (LIM=511), count forward to 511, one more edge → P=0. 2-clk glitches on A → no P change.
- Jump A and B together 00→11 → ERR=1, P unchanged; CLR_ERR pulse → ERR=0; simultaneous illegal edge plus CLR_ERR → ERR stays 1.
- At P=37, Z pulse of 10 clk coinciding with a forward edge → P=0, STEP=0, DIR=1. CLR asserted in the same cycle as the Z edge → P=0.
- Assert RST_N low while mid-count at P=88 → all outputs 0 immediately. Release with A=B=1 → no count on the PRIME load; the next forward edge gives P=1.
